// File: rtl/fb_copy_ctrl_if.sv
// Shared-source read port and display-RAM write port of the frame copier.
interface fb_copy_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              src_req;
  logic              src_gnt;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_data;
  logic              dst_we;
  logic [ADDR_W:0]   dst_addr;
  logic [7:0]        dst_data;

  modport master (
    output src_req, src_addr, dst_we, dst_addr, dst_data,
    input  src_gnt, src_data
  );

  modport slave (
    input  src_req, src_addr, dst_we, dst_addr, dst_data,
    output src_gnt, src_data
  );
endinterface

// File: rtl/fb_copy_ctrl.sv
// Double-buffer frame copier: on frame_complete it streams the LCD frame RAM
// through the shared read port into the back display bank, then swaps banks
// so scanout only ever sees complete frames.
module fb_copy_ctrl #(
  parameter int FRAME_BYTES = 768,
  parameter int ADDR_W      = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_complete,
  fb_copy_ctrl_if.master bus,
  output logic          front_bank,
  output logic          busy,
  output logic [7:0]    frame_count,
  output logic          dropped
);

  typedef enum logic [1:0] {IDLE, COPY, DRAIN, SWAP} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_BYTES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              rd_valid;
  logic              pending;
  logic              grant;

  // src_req is only ever high in COPY, so a grant outside COPY is ignored.
  assign grant = (state == COPY) && bus.src_gnt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: one cycle of DRAIN lets the last granted byte land before the swap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_complete || pending) state_nxt = COPY;
      COPY:    if (grant && (rd_idx == LAST_IDX)) state_nxt = DRAIN;
      DRAIN:   state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state; write-side outputs forced to 0 when idle.
  always_comb begin
    bus.src_req  = (state == COPY);
    bus.src_addr = (state == COPY) ? rd_idx : '0;
    busy         = (state != IDLE);
    bus.dst_we   = rd_valid;
    bus.dst_addr = rd_valid ? {~front_bank, wr_idx} : '0;
    bus.dst_data = rd_valid ? bus.src_data : 8'h00;
  end

  // Read index and the read-data-valid flag that follows each granted address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_idx   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= grant;
      if (state == IDLE) rd_idx <= '0;
      else if (grant && (rd_idx != LAST_IDX)) rd_idx <= rd_idx + 1'b1;
    end
  end

  // Write index captured with the granted address; meaningful only with rd_valid.
  always_ff @(posedge clk) begin
    if (grant) wr_idx <= rd_idx;
  end

  // Bank swap and completed-frame counter, updated only in SWAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_bank  <= 1'b0;
      frame_count <= 8'd0;
    end else if (state == SWAP) begin
      front_bank  <= ~front_bank;
      frame_count <= frame_count + 8'd1;
    end
  end

  // One frame request can wait while busy; any further request is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      dropped <= 1'b0;
    end else begin
      dropped <= 1'b0;
      if (state == IDLE) begin
        if (frame_complete || pending) pending <= 1'b0;
        if (frame_complete && pending) dropped <= 1'b1;
      end else if (frame_complete) begin
        if (pending) dropped <= 1'b1;
        else         pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_copy_ctrl.sv
// Directed bench for fb_copy_ctrl with a write scoreboard fed from granted reads.
module tb_fb_copy_ctrl;

  localparam int FB  = 768;
  localparam int AW  = 10;
  localparam int FB2 = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fc = 1'b0;
  logic       fc2 = 1'b0;
  logic       front_bank, busy, dropped;
  logic [7:0] frame_count;
  logic       front2, busy2, dropped2;
  logic [7:0] count2;

  fb_copy_ctrl_if #(.ADDR_W(AW)) bus ();
  fb_copy_ctrl_if #(.ADDR_W(AW)) bus2 ();

  fb_copy_ctrl #(.FRAME_BYTES(FB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .frame_complete(fc), .bus(bus),
    .front_bank(front_bank), .busy(busy), .frame_count(frame_count), .dropped(dropped)
  );

  fb_copy_ctrl #(.FRAME_BYTES(FB2), .ADDR_W(AW)) dut2 (
    .clk(clk), .reset(reset), .frame_complete(fc2), .bus(bus2),
    .front_bank(front2), .busy(busy2), .frame_count(count2), .dropped(dropped2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int ncyc = 0;
  int fc_cyc = 0;
  int gnt_mode = 0;
  int mark = 0;

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) ncyc++;

  // Grant pattern changes just after the edge so it is stable for DUT and monitor.
  always @(posedge clk) begin
    #1;
    if (gnt_mode == 0) bus.src_gnt = 1'b1;
    else               bus.src_gnt = ~bus.src_gnt;
  end

  // Source RAMs: data appears the cycle after a granted address.
  always @(posedge clk) begin
    if (bus.src_req && bus.src_gnt)   bus.src_data  <= pat(bus.src_addr);
    if (bus2.src_req && bus2.src_gnt) bus2.src_data <= pat(bus2.src_addr);
  end

  typedef struct {
    logic [AW:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t q[$];
  bit  model_front = 1'b0;
  int  exp_idx = 0;
  bit  prev_gnt = 1'b0;
  bit  was_busy = 1'b0;
  int  seen_mark = 0;
  int  req_first = -1, we_first = -1, we_last = -1, busy_fall = -1;
  int  copy_writes = 0;
  int  drop_cnt = 0;

  // Monitor: push expected writes on granted reads, pop and compare on dst_we.
  always @(negedge clk) begin
    wr_t e;
    if (mark != seen_mark) begin
      seen_mark   = mark;
      req_first   = -1;
      we_first    = -1;
      we_last     = -1;
      busy_fall   = -1;
      copy_writes = 0;
    end
    if (reset) begin
      q.delete();
      model_front = 1'b0;
      exp_idx     = 0;
      prev_gnt    = 1'b0;
      was_busy    = 1'b0;
      check("we_in_reset", 32'(bus.dst_we), 32'd0);
    end else begin
      if (bus.src_req && req_first < 0) req_first = ncyc;
      if (dropped) drop_cnt++;
      if (busy) was_busy = 1'b1;
      else if (was_busy) begin
        was_busy = 1'b0;
        if (busy_fall < 0) busy_fall = ncyc;
      end
      if (bus.dst_we) begin
        check("we_after_grant", 32'(prev_gnt), 32'd1);
        check("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("dst_addr", 32'(bus.dst_addr), 32'(e.addr));
          check("dst_data", 32'(bus.dst_data), 32'(e.data));
          if (e.addr[AW-1:0] == AW'(FB - 1)) model_front = ~model_front;
        end
        copy_writes++;
        if (we_first < 0) we_first = ncyc;
        we_last = ncyc;
      end
      prev_gnt = bus.src_req && bus.src_gnt;
      if (prev_gnt) begin
        check("src_addr", 32'(bus.src_addr), 32'(exp_idx));
        e.addr = {~model_front, exp_idx[AW-1:0]};
        e.data = pat(exp_idx[AW-1:0]);
        q.push_back(e);
        exp_idx = (exp_idx == FB - 1) ? 0 : exp_idx + 1;
      end
    end
  end

  task automatic pulse();
    @(negedge clk);
    fc = 1'b1;
    fc_cyc = ncyc;
    @(negedge clk);
    fc = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    int idle = 0;
    while (idle < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy) idle++;
      else       idle = 0;
    end
    check("idle_timeout", 32'(idle >= 3), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_src_req"},  32'(bus.src_req),  32'd0);
    check({tag, "_src_addr"}, 32'(bus.src_addr), 32'd0);
    check({tag, "_dst_we"},   32'(bus.dst_we),   32'd0);
    check({tag, "_dst_addr"}, 32'(bus.dst_addr), 32'd0);
    check({tag, "_dst_data"}, 32'(bus.dst_data), 32'd0);
    check({tag, "_front"},    32'(front_bank),   32'd0);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_count"},    32'(frame_count),  32'd0);
    check({tag, "_dropped"},  32'(dropped),      32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    bus2.src_gnt = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Grant always high: exact timing of one full copy.
    mark++;
    pulse();
    wait_idle(2000);
    check("t1_req_first",  32'(req_first),   32'(fc_cyc + 1));
    check("t1_we_first",   32'(we_first),    32'(fc_cyc + 2));
    check("t1_we_last",    32'(we_last),     32'(fc_cyc + 769));
    check("t1_writes",     32'(copy_writes), 32'd768);
    check("t1_busy_fall",  32'(busy_fall),   32'(fc_cyc + 771));
    check("t1_front",      32'(front_bank),  32'd1);
    check("t1_count",      32'(frame_count), 32'd1);
    check("t1_busy",       32'(busy),        32'd0);

    // Alternating grant: copy stretches to about twice as long.
    gnt_mode = 1;
    mark++;
    pulse();
    wait_idle(4000);
    gnt_mode = 0;
    check("t2_writes",   32'(copy_writes), 32'd768);
    check("t2_stretch",  32'((we_last - we_first) >= 1500), 32'd1);
    check("t2_front",    32'(front_bank),  32'd0);
    check("t2_count",    32'(frame_count), 32'd2);

    // Second request mid-copy is queued, not dropped.
    d0 = drop_cnt;
    mark++;
    pulse();
    repeat (98) @(negedge clk);
    pulse();
    wait_idle(4000);
    check("t3_no_drop", 32'(drop_cnt),    32'(d0));
    check("t3_writes",  32'(copy_writes), 32'd1536);
    check("t3_front",   32'(front_bank),  32'd0);
    check("t3_count",   32'(frame_count), 32'd4);

    // Three requests in one copy: the third is dropped.
    d0 = drop_cnt;
    mark++;
    pulse();
    repeat (99) @(negedge clk);
    pulse();
    repeat (99) @(negedge clk);
    pulse();
    wait_idle(4000);
    check("t4_one_drop", 32'(drop_cnt),    32'(d0 + 1));
    check("t4_writes",   32'(copy_writes), 32'd1536);
    check("t4_front",    32'(front_bank),  32'd0);
    check("t4_count",    32'(frame_count), 32'd6);

    // Reset in the middle of a copy.
    mark++;
    pulse();
    n = 0;
    while (copy_writes < 300 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_300", 32'(copy_writes >= 300), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("t5_async");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_front_after", 32'(front_bank),  32'd0);
    check("t5_count_after", 32'(frame_count), 32'd0);
    mark++;
    pulse();
    wait_idle(2000);
    check("t5_writes", 32'(copy_writes), 32'd768);
    check("t5_front",  32'(front_bank),  32'd1);
    check("t5_count",  32'(frame_count), 32'd1);

    // 256 short frames on the small instance: counter wraps to 0.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      fc2 = 1'b1;
      @(negedge clk);
      fc2 = 1'b0;
      n = 0;
      while (busy2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("t6_count", 32'(count2), 32'((i + 1) % 256));
    end
    check("t6_front", 32'(front2), 32'd0);
    check("t6_busy",  32'(busy2),  32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fb_copy_ctrl.md
Name: fb_copy_ctrl

Overview:
- Double-buffer sequencer between the CPU-visible LCD frame RAM (768 bytes at 0x1000–0x12FF) and the video scanout buffers.
- On each frame_complete pulse from the minx core, copies the whole frame through a shared read port (request/grant with the CPU bus) into the back display bank, then swaps banks.
- Scanout always reads front_bank, so it never shows a half-written frame.

Parameters:
FRAME_BYTES, 768, bytes copied per frame (96x64 / 8).
ADDR_W, 10, source address width; destination address is ADDR_W+1 bits.

Ports:
clk  in  1  system clock (clk_sys domain).
reset  in  1  asynchronous, active-high reset.
frame_complete  in  1  single-cycle pulse: CPU finished a frame.
src_req  out  1  request for the shared source RAM read port.
src_gnt  in  1  grant; the cycle with src_req&src_gnt issues src_addr.
src_addr  out  ADDR_W  source byte address, 0..FRAME_BYTES-1.
src_data  in  8  source read data, valid the cycle after a granted address.
dst_we  out  1  write strobe into display RAM.
dst_addr  out  ADDR_W+1  {back_bank, byte index}.
dst_data  out  8  byte written.
front_bank  out  1  bank scanout reads.
busy  out  1  copy in progress.
frame_count  out  8  completed swaps, wraps 255->0.
dropped  out  1  one-cycle pulse: a frame request was discarded.

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal pending=0, rd_idx=0, rd_valid=0. Back bank = ~front_bank = 1.
- Reset mid-copy: abort immediately. front_bank and frame_count return to 0. No further dst_we.
- States: IDLE, COPY, DRAIN, SWAP.
- IDLE:
  - frame_complete=1 or pending=1 -> COPY next edge; pending cleared.
  - busy and src_req go high on entry to COPY (registered); rd_idx=0.
- COPY:
  - src_req=1, src_addr=rd_idx.
  - On a cycle with src_gnt=1: rd_idx increments; rd_valid<=1 and wr_idx<=rd_idx.
  - On a cycle with src_gnt=0: rd_idx holds; rd_valid<=0.
  - After the cycle granting rd_idx=FRAME_BYTES-1 -> DRAIN; src_req drops in the same edge.
- Write path (all states, registered):
  - If rd_valid: dst_we=1, dst_addr={~front_bank, wr_idx}, dst_data=src_data sampled that cycle. Otherwise dst_we=0.
  - Latency from granted address to dst_we: exactly 1 cycle.
  - dst_data must not be used when dst_we=0.
- DRAIN: one cycle for the final write, then -> SWAP.
- SWAP (one cycle):
  - front_bank toggles; frame_count+1; busy<=0.
  - -> IDLE. If pending, the next COPY starts the following cycle.
- Pending / drop:
  - frame_complete while busy (COPY/DRAIN/SWAP) and pending=0 -> pending<=1.
  - frame_complete while pending=1 -> dropped pulses 1 cycle; pending stays 1.
  - frame_complete in IDLE with pending=1 cannot occur (IDLE exits in one cycle). If it does, treat it as a start and pulse dropped.
- src_gnt is ignored when src_req=0. The arbiter may withdraw grant any cycle; a stall only delays the copy, never corrupts it.
- Widths: rd_idx compares against FRAME_BYTES-1 exactly; no wrap of src_addr beyond it.

Test Plan:
- Grant tied high, frame_complete pulse at cycle 0:
  - src_req=1 cycles 1..768 with src_addr 0..767.
  - dst_we cycles 2..769, dst_addr 0x400..0x6FF (bank 1), data matches source pattern addr^0x5A.
  - front_bank=1 and frame_count=1 from cycle 771; busy=0.
- Grant toggling 1,0,1,0:
  - Copy takes about 2x cycles.
  - Every byte 0..767 written exactly once, in order, with correct data.
  - No dst_we on the cycle following a non-granted cycle.
- Second frame_complete at cycle 100 of a copy:
  - No dropped pulse; the second copy starts right after SWAP into bank 0.
  - front_bank returns to 0; frame_count=2.
- Three frame_complete pulses during one copy: exactly one dropped pulse (on the third); two swaps total.
- Reset asserted at byte 300:
  - All outputs 0 asynchronously; no writes afterward.
  - A subsequent frame_complete copies the full frame into bank 1.
- 256 frames with grant high: frame_count wraps to 0; front_bank=0.
